// File: rtl/sdio_pkg.sv
// Shared constants and state encoding for the SDIO CMD-line response transmitter.
package sdio_pkg;

   // Response frame layout: start, direction, 6-bit index, 32-bit argument, CRC7, end.
   localparam int         RSP_LEN        = 48;
   localparam int         CRC_LEN        = 7;
   localparam logic       START_BIT      = 1'b0;
   localparam logic       DIR_BIT        = 1'b0;   // card-to-host
   localparam logic       END_BIT        = 1'b1;
   localparam logic [6:0] CRC_FIELD_ONES = 7'h7F;  // R3/R4 carry no real CRC

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_NCR,
      ST_DATA,
      ST_CRC,
      ST_END
   } rsp_state_t;

endpackage

// File: rtl/sdio_crc7_lfsr.sv
// Serial CRC7 generator: one message bit per enabled clock, MSB first.
module sdio_crc7_lfsr #(
   parameter logic [6:0] POLYNOMIAL = 7'h09,
   parameter logic [6:0] SEED       = 7'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       en,
   input  logic       din,
   output logic [6:0] crc
);

   logic [6:0] r_crc;
   logic       w_fb;

   assign w_fb = din ^ r_crc[6];

   // Shift the remainder by one message bit; clear reloads the seed for a new frame.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: registers are written with <= so every flop samples pre-edge values.
      if (!rst_n) begin
         r_crc <= SEED;
      end else if (clear) begin
         r_crc <= SEED;
      end else if (en) begin
         r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? POLYNOMIAL : 7'h00);
      end
   end

   assign crc = r_crc;

endmodule

// File: rtl/sdio_rsp_tx.sv
// SDIO device response transmitter: waits N_CR bit periods, then serialises
// start/dir/index/arg, the CRC7 (or all ones) and the end bit onto CMD.
module sdio_rsp_tx
   import sdio_pkg::*;
#(
   parameter int         NCR_BITS   = 2,
   parameter logic [6:0] POLYNOMIAL = 7'h09,
   parameter logic [6:0] SEED       = 7'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bit_en,
   input  logic        rsp_valid,
   output logic        rsp_ready,
   input  logic [5:0]  rsp_index,
   input  logic [31:0] rsp_arg,
   input  logic        rsp_no_crc,
   input  logic        abort,
   output logic        cmd_out,
   output logic        cmd_oe,
   output logic        busy,
   output logic        done
);

   // Bits ahead of the CRC field: start, dir, index, arg.
   localparam int         DATA_BITS = RSP_LEN - CRC_LEN - 1;
   localparam logic [5:0] NCR_LOAD  = 6'(NCR_BITS);
   localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);
   localparam logic [5:0] CRC_LAST  = 6'(CRC_LEN - 1);

   rsp_state_t           r_state;
   logic [5:0]           r_cnt;       // NCR countdown, data/CRC bits remaining, END phase
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_no_crc;
   logic                 r_cmd_out;
   logic                 r_cmd_oe;
   logic                 r_done;

   logic                 w_accept;
   logic                 w_crc_clear;
   logic                 w_crc_en;
   logic [6:0]           w_crc;

   // NOTE: rsp_ready looks at abort combinationally so an abort in the same
   // cycle as rsp_valid blocks the handshake rather than racing it.
   assign rsp_ready   = (r_state == ST_IDLE) && !abort;
   assign w_accept    = rsp_valid && rsp_ready;
   assign w_crc_clear = w_accept || abort;
   // The bit going on the line is the bit going into the CRC.
   assign w_crc_en    = bit_en && (r_state == ST_DATA);

   sdio_crc7_lfsr #(
      .POLYNOMIAL (POLYNOMIAL),
      .SEED       (SEED)
   ) u_crc (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (w_crc_clear),
      .en    (w_crc_en),
      .din   (r_shift[DATA_BITS-1]),
      .crc   (w_crc)
   );

   // Frame sequencer: state, bit counter, shift register and registered line outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_shift   <= '0;
         r_no_crc  <= 1'b0;
         r_cmd_out <= 1'b1;
         r_cmd_oe  <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (abort) begin
            r_state   <= ST_IDLE;
            r_cmd_out <= 1'b1;
            r_cmd_oe  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_accept) begin
                     r_shift  <= {START_BIT, DIR_BIT, rsp_index, rsp_arg};
                     r_no_crc <= rsp_no_crc;
                     if (NCR_BITS == 0) begin
                        r_state <= ST_DATA;
                        r_cnt   <= DATA_LAST;
                     end else begin
                        r_state <= ST_NCR;
                        r_cnt   <= NCR_LOAD;
                     end
                  end
               end
               ST_NCR: begin
                  if (bit_en) begin
                     if (r_cnt == 6'd1) begin
                        r_state <= ST_DATA;
                        r_cnt   <= DATA_LAST;
                     end else begin
                        r_cnt <= r_cnt - 6'd1;
                     end
                  end
               end
               ST_DATA: begin
                  if (bit_en) begin
                     r_cmd_oe  <= 1'b1;
                     r_cmd_out <= r_shift[DATA_BITS-1];
                     r_shift   <= {r_shift[DATA_BITS-2:0], 1'b0};
                     if (r_cnt == 6'd0) begin
                        r_state <= ST_CRC;
                        r_cnt   <= CRC_LAST;
                     end else begin
                        r_cnt <= r_cnt - 6'd1;
                     end
                  end
               end
               ST_CRC: begin
                  if (bit_en) begin
                     r_cmd_out <= r_no_crc ? CRC_FIELD_ONES[r_cnt[2:0]] : w_crc[r_cnt[2:0]];
                     if (r_cnt == 6'd0) begin
                        r_state <= ST_END;
                        r_cnt   <= 6'd1;
                     end else begin
                        r_cnt <= r_cnt - 6'd1;
                     end
                  end
               end
               ST_END: begin
                  if (bit_en) begin
                     if (r_cnt != 6'd0) begin
                        r_cmd_out <= END_BIT;
                        r_cnt     <= 6'd0;
                     end else begin
                        r_cmd_out <= 1'b1;
                        r_cmd_oe  <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= ST_IDLE;
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign cmd_out = r_cmd_out;
   assign cmd_oe  = r_cmd_oe;
   assign done    = r_done;
   assign busy    = (r_state != ST_IDLE);

endmodule

// File: doc/sdio_rsp_tx.md
# sdio_rsp_tx

SDIO device-side command-line response transmitter. It accepts one response request from the command decoder, waits the N_CR turnaround, then serialises a 48-bit response frame onto the CMD line. It sequences an internal CRC7 generator over the first 40 frame bits and appends the CRC and the end bit. It sits between the SDIO command engine and the CMD pad tristate.

## Interface
Parameters:
- NCR_BITS, default 2: bit periods of line release between request acceptance and the start bit (0–63).
- POLYNOMIAL, default 7'h09: CRC7 feedback taps, x^7+x^3+1.
- SEED, default 7'h00: CRC7 initial value at frame start.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- bit_en  in  1  bit strobe; the frame advances by one bit on each clk edge where this is high.
- rsp_valid  in  1  response request.
- rsp_ready  out  1  request accepted on an edge where rsp_valid && rsp_ready.
- rsp_index  in  6  response command index, frame bits 45:40.
- rsp_arg  in  32  response argument, frame bits 39:8.
- rsp_no_crc  in  1  drive 7'h7F in the CRC field (R3/R4).
- abort  in  1  synchronous cancel.
- cmd_out  out  1  CMD line data.
- cmd_oe  out  1  CMD line output enable.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-clk pulse at frame completion.

## Operation
- Frame, MSB first: bit47 = 0 (start), bit46 = 0 (card to host), 45:40 index, 39:8 arg, 7:1 CRC7, bit0 = 1 (end).
- States: IDLE, NCR, DATA, CRC, END.
- IDLE: rsp_ready = !abort. On acceptance, latch index, arg and no_crc; load the NCR counter with NCR_BITS; reset the CRC to SEED.
  - Go to NCR, or straight to DATA if NCR_BITS = 0.
- NCR: cmd_oe = 0. Decrement on each bit_en. On the strobe that reaches 0, go to DATA.
- DATA: on each bit_en, drive the next frame bit (47 down to 8) onto cmd_out and clock that same bit into the CRC. On the bit-8 strobe, go to CRC.
- CRC: the CRC is held (no update). On each bit_en, drive crc[6..0] MSB first, or 1s if no_crc. After 7 strobes, go to END.
- END: on the first bit_en, drive the end bit = 1. On the next bit_en, set cmd_oe = 0, pulse done and go to IDLE.
- CRC arithmetic: next = {crc[5:0], 0} ^ (b ^ crc[6] ? POLY : 0), 7 bits wide, no overflow bit.
- abort (any state): next edge → IDLE with cmd_oe = 0 and cmd_out = 1. No done pulse. Latched request discarded.
- abort in the same cycle as rsp_valid: abort wins; the request is not accepted.
- rst_n asserted mid-frame: outputs go to reset values immediately (asynchronously).

## Timing
- Reset values: cmd_out = 1, cmd_oe = 0, rsp_ready = 1 (after rst_n deasserts, subject to abort), busy = 0, done = 0. CRC = SEED, state = IDLE.
- cmd_out and cmd_oe are registered; each changes only on bit_en edges or on abort/reset.
- Every frame bit is held exactly one bit period, from one strobe to the next.
- Line timing after acceptance:
  - NCR_BITS strobes of cmd_oe = 0.
  - 48 strobes with cmd_oe = 1.
  - cmd_oe falls on the 49th strobe after NCR.
- done pulses on the same edge cmd_oe falls. rsp_ready is high on the following cycle.
- With bit_en held high continuously, the acceptance-to-done latency is NCR_BITS + 49 clks.
- No back-to-back acceptance: at least one IDLE cycle separates frames.

## Structure
- Package sdio_pkg holds:
  - frame constants: RSP_LEN = 48, START/DIR/END bit values, CRC_FIELD_ONES = 7'h7F;
  - the state enum.
- One sub-module, sdio_crc7_lfsr:
  - serial CRC7 with parameters POLYNOMIAL/SEED;
  - ports clk, rst_n, clear, en, din, crc[6:0].
- The FSM, counters and shift register stay in sdio_rsp_tx.

## Test plan
- Basic R1, NCR_BITS = 2, bit_en = 1: index 6'h11, arg 32'h0000_0900 → 2 clks oe = 0, then frame bits 0,0,010001,arg, CRC 7'h33, end 1; done at clk 51.
- rsp_no_crc = 1, index 6'h3F, arg 32'h00FF_8000 → CRC field is seven 1s, end bit 1, frame length 48.
- bit_en every 4th clk → each bit held 4 clks. No change on non-strobe edges. Latency (2+49)×4 clks.
- abort at DATA bit 30 → next clk cmd_oe = 0, cmd_out = 1, no done, rsp_ready = 1. A following request transmits with a correct CRC (SEED restored).
- abort and rsp_valid together in IDLE → not accepted, busy stays 0. NCR_BITS = 0 → start bit driven on the first strobe after acceptance.
- rst_n low mid-CRC field → immediate cmd_oe = 0, cmd_out = 1, busy = 0. Release → rsp_ready = 1.
